// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle SLL/SRL/SRA/ROL sequencer around one logical barrel shifter
module barrel_shifter #(
  parameter int NBITS = 32,
  parameter int AW    = $clog2(NBITS)
) (
  input  logic [NBITS-1:0] shift_in,
  input  logic [AW-1:0]    shift_amt,
  input  logic             shift_right,
  output logic [NBITS-1:0] shift_out
);

  logic [NBITS-1:0] stage [AW+1];

  // Log-depth stages; stage k moves by 2**k when the matching amount bit is set.
  always_comb begin
    stage[0] = shift_in;
    for (int k = 0; k < AW; k++) begin
      if (shift_amt[k]) begin
        stage[k+1] = shift_right ? (stage[k] >> (1 << k)) : (stage[k] << (1 << k));
      end else begin
        stage[k+1] = stage[k];
      end
    end
    shift_out = stage[AW];
  end

endmodule

module shift_sequencer #(
  parameter int NBITS = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_valid,
  output logic                     start_ready,
  input  logic [1:0]               op,
  input  logic [NBITS-1:0]         operand,
  input  logic [$clog2(NBITS)-1:0] amount,
  output logic [NBITS-1:0]         result,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic                     busy
);

  localparam int AW = $clog2(NBITS);
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [NBITS-1:0] operand_q, operand_d;
  logic [AW-1:0]    amount_q, amount_d;
  logic [NBITS-1:0] partial_q, partial_d;
  logic [NBITS-1:0] result_q, result_d;

  logic [NBITS-1:0] sh_in, sh_out;
  logic [AW-1:0]    sh_amt;
  logic             sh_right;
  logic [AW:0]      rol_back_amt;

  // Only reached with amount != 0, so the truncated value never wraps to a zero-distance shift.
  assign rol_back_amt = (AW+1)'(NBITS) - {1'b0, amount_q};

  barrel_shifter #(.NBITS(NBITS), .AW(AW)) u_shifter (
    .shift_in    (sh_in),
    .shift_amt   (sh_amt),
    .shift_right (sh_right),
    .shift_out   (sh_out)
  );

  always_comb begin
    sh_in    = operand_q;
    sh_amt   = amount_q;
    sh_right = (op_q == OP_SRL) || (op_q == OP_SRA);
    if (state_q == PASS2) begin
      sh_right = 1'b1;
      if (op_q == OP_SRA) begin
        sh_in = '1;
      end else begin
        sh_amt = rol_back_amt[AW-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    operand_d = operand_q;
    amount_d  = amount_q;
    partial_d = partial_q;
    result_d  = result_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          op_d      = op;
          operand_d = operand;
          amount_d  = amount;
          state_d   = PASS1;
        end
      end
      PASS1: begin
        partial_d = sh_out;
        if ((op_q == OP_SLL) || (op_q == OP_SRL) || (amount_q == '0)) begin
          result_d = sh_out;
          state_d  = DONE;
        end else begin
          state_d = PASS2;
        end
      end
      PASS2: begin
        // SRA fills the vacated top bits with the sign using the inverted all-ones mask.
        if (op_q == OP_SRA) begin
          result_d = partial_q | (operand_q[NBITS-1] ? ~sh_out : '0);
        end else begin
          result_d = partial_q | sh_out;
        end
        state_d = DONE;
      end
      DONE: begin
        if (result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      operand_q <= '0;
      amount_q  <= '0;
      partial_q <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      operand_q <= operand_d;
      amount_q  <= amount_d;
      partial_q <= partial_d;
      result_q  <= result_d;
    end
  end

  assign start_ready  = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == DONE);
  assign result       = result_q;

endmodule
